// File: rtl/calc_mem_pkg.sv
// Shared definitions for the operand/result scratch-memory controller.
// Holds bus-width defaults, the controller FSM state encoding and the op encoding.
package calc_mem_pkg;

  localparam int unsigned DATA_W_DEF = 16;
  localparam int unsigned ADDR_W_DEF = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR   = 2'd1,
    RD1  = 2'd2,
    RD2  = 2'd3
  } state_e;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: a sole requester wins outright, and on a tie
// the requester that was not granted last time wins.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] grant_onehot,
  output logic       grant_idx
);

  always_comb begin
    grant_idx    = 1'b0;
    grant_onehot = '0;
    unique case (req)
      2'b01:   grant_idx = 1'b0;
      2'b10:   grant_idx = 1'b1;
      2'b11:   grant_idx = ~last_grant;
      default: grant_idx = 1'b0;
    endcase
    if (req != 2'b00) begin
      grant_onehot = grant_idx ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin controller time-sharing the 4x16 scratch memory between the
// operand-load (0) and result-writeback (1) requesters; 1-cycle write, 2-cycle read.
module mem_arbiter
  import calc_mem_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            req_valid,
  input  logic [1:0]            req_write,
  input  logic [2*ADDR_W-1:0]   req_addr,
  input  logic [2*DATA_W-1:0]   req_wdata,
  output logic [1:0]            req_ack,
  output logic [DATA_W-1:0]     rd_data,
  output logic [1:0]            rd_valid,
  output logic                  busy,
  output logic                  mem_oe,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  inout  wire  [DATA_W-1:0]     mem_data
);

  state_e              state_q;
  logic                last_grant_q;
  logic                owner_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                oe_q;
  logic                we_q;
  logic [1:0]          ack_q;
  logic [1:0]          rd_valid_q;
  logic [DATA_W-1:0]   rd_data_q;

  logic [1:0]          grant_onehot;
  logic                grant_idx;
  logic [ADDR_W-1:0]   sel_addr_d;
  logic [DATA_W-1:0]   sel_wdata_d;
  op_e                 sel_op_d;

  rr_arb2 u_arb (
    .req          (req_valid),
    .last_grant   (last_grant_q),
    .grant_onehot (grant_onehot),
    .grant_idx    (grant_idx)
  );

  always_comb begin
    sel_addr_d  = '0;
    sel_wdata_d = '0;
    sel_op_d    = OP_RD;
    if (grant_idx) begin
      sel_addr_d  = req_addr[2*ADDR_W-1:ADDR_W];
      sel_wdata_d = req_wdata[2*DATA_W-1:DATA_W];
      sel_op_d    = op_e'(req_write[1]);
    end else begin
      sel_addr_d  = req_addr[ADDR_W-1:0];
      sel_wdata_d = req_wdata[DATA_W-1:0];
      sel_op_d    = op_e'(req_write[0]);
    end
  end

  // Strobes are set on entry to each state so they depend only on registered state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      oe_q         <= 1'b0;
      we_q         <= 1'b0;
      ack_q        <= '0;
      rd_valid_q   <= '0;
      rd_data_q    <= '0;
    end else begin
      ack_q      <= '0;
      rd_valid_q <= '0;
      unique case (state_q)
        IDLE: begin
          if (req_valid != 2'b00) begin
            owner_q      <= grant_idx;
            last_grant_q <= grant_idx;
            addr_q       <= sel_addr_d;
            wdata_q      <= sel_wdata_d;
            ack_q        <= grant_onehot;
            if (sel_op_d == OP_WR) begin
              state_q <= WR;
              we_q    <= 1'b1;
            end else begin
              state_q <= RD1;
              oe_q    <= 1'b1;
            end
          end
        end
        WR: begin
          state_q <= IDLE;
          we_q    <= 1'b0;
        end
        RD1: begin
          state_q <= RD2;
        end
        RD2: begin
          rd_data_q           <= mem_data;
          rd_valid_q[owner_q] <= 1'b1;
          oe_q                <= 1'b0;
          state_q             <= IDLE;
        end
      endcase
    end
  end

  assign mem_data = (state_q == WR) ? wdata_q : 'z;

  assign req_ack  = ack_q;
  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign busy     = (state_q != IDLE);
  assign mem_oe   = oe_q;
  assign mem_we   = we_q;
  assign mem_addr = addr_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter with a behavioural 4x16 registered-output memory.
module tb_mem_arbiter;

  logic        clk;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_write;
  logic [3:0]  req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  req_ack;
  logic [15:0] rd_data;
  logic [1:0]  rd_valid;
  logic        busy;
  logic        mem_oe;
  logic        mem_we;
  logic [1:0]  mem_addr;
  wire  [15:0] mem_data;

  logic        v  [2];
  logic        w  [2];
  logic [1:0]  ad [2];
  logic [15:0] wd [2];

  assign req_valid = {v[1], v[0]};
  assign req_write = {w[1], w[0]};
  assign req_addr  = {ad[1], ad[0]};
  assign req_wdata = {wd[1], wd[0]};

  mem_arbiter #(.DATA_W(16), .ADDR_W(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_ack   (req_ack),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .busy      (busy),
    .mem_oe    (mem_oe),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] mem [4] = '{default: 16'h0000};
  logic [15:0] dout = 16'h0000;
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_data;
    if (mem_oe) dout <= mem[mem_addr];
  end
  assign mem_data = mem_oe ? dout : 'z;

  typedef struct { int idx; bit rd; } ack_t;
  typedef struct { int idx; logic [15:0] data; } rd_t;
  typedef struct { logic [15:0] data; logic [1:0] addr; } wr_t;

  ack_t exp_ack[$];
  rd_t  exp_rd[$];
  wr_t  exp_wr[$];
  int   lat_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int oe_run = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic exp_a(input int idx, input bit rd);
    ack_t e;
    e.idx = idx; e.rd = rd;
    exp_ack.push_back(e);
  endtask

  task automatic exp_r(input int idx, input logic [15:0] data);
    rd_t e;
    e.idx = idx; e.data = data;
    exp_rd.push_back(e);
  endtask

  task automatic exp_w(input logic [15:0] data, input logic [1:0] addr);
    wr_t e;
    e.data = data; e.addr = addr;
    exp_wr.push_back(e);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents ack, rd_valid or a write strobe.
  ack_t m_a;
  rd_t  m_r;
  wr_t  m_w;
  int   m_t;
  always @(negedge clk) begin
    if (rst) begin
      oe_run = 0;
    end else begin
      chk("oe_we_exclusive", {31'd0, mem_oe & mem_we}, 32'd0);
      if (req_ack != 2'b00) begin
        if (exp_ack.size() == 0) begin
          chk("unexpected_ack", {30'd0, req_ack}, 32'd0);
        end else begin
          m_a = exp_ack.pop_front();
          chk("ack_order", {30'd0, req_ack}, (m_a.idx == 1) ? 32'd2 : 32'd1);
          if (m_a.rd) lat_q.push_back(cyc);
        end
      end
      if (rd_valid != 2'b00) begin
        if (exp_rd.size() == 0) begin
          chk("unexpected_rd_valid", {30'd0, rd_valid}, 32'd0);
        end else begin
          m_r = exp_rd.pop_front();
          chk("rd_valid_owner", {30'd0, rd_valid}, (m_r.idx == 1) ? 32'd2 : 32'd1);
          chk("rd_data", {16'd0, rd_data}, {16'd0, m_r.data});
          if (lat_q.size() != 0) begin
            m_t = lat_q.pop_front();
            chk("rd_latency", cyc, m_t + 2);
          end
        end
      end
      if (mem_we) begin
        if (exp_wr.size() == 0) begin
          chk("unexpected_write", {31'd0, mem_we}, 32'd0);
        end else begin
          m_w = exp_wr.pop_front();
          chk("wr_bus", {16'd0, mem_data}, {16'd0, m_w.data});
          chk("wr_addr", {30'd0, mem_addr}, {30'd0, m_w.addr});
        end
      end
      if (mem_oe) begin
        oe_run++;
      end else if (oe_run != 0) begin
        chk("oe_pulse_len", oe_run, 2);
        oe_run = 0;
      end
    end
  end

  task automatic do_req(input int r, input bit wr, input logic [1:0] a, input logic [15:0] d);
    int n;
    n = 0;
    v[r] = 1'b1; w[r] = wr; ad[r] = a; wd[r] = d;
    forever begin
      @(posedge clk); #1;
      if (req_ack[r]) break;
      n++;
      if (n > 30) begin
        chk("ack_timeout", 32'd0, 32'd1);
        break;
      end
    end
    v[r] = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (busy && n < 50);
    if (busy) chk("idle_timeout", 32'd1, 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_busy"},     {31'd0, busy},   32'd0);
    chk({tag, "_oe"},       {31'd0, mem_oe}, 32'd0);
    chk({tag, "_we"},       {31'd0, mem_we}, 32'd0);
    chk({tag, "_ack"},      {30'd0, req_ack},  32'd0);
    chk({tag, "_rd_valid"}, {30'd0, rd_valid}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 2; i++) begin
      v[i] = 1'b0; w[i] = 1'b0; ad[i] = '0; wd[i] = '0;
    end
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_quiet("reset");
    chk("reset_rd_data", {16'd0, rd_data}, 32'd0);
    chk("reset_addr", {30'd0, mem_addr}, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk_quiet("idle");
    end

    // Single write then read by requester 0
    exp_a(0, 1'b0); exp_w(16'hA5C3, 2'd2);
    do_req(0, 1'b1, 2'd2, 16'hA5C3);
    wait_idle();
    exp_a(0, 1'b1); exp_r(0, 16'hA5C3);
    do_req(0, 1'b0, 2'd2, 16'h0000);
    wait_idle();

    // Tie from reset release: requester 0 wins first
    rst = 1'b1;
    exp_a(0, 1'b0); exp_w(16'h0011, 2'd0);
    exp_a(1, 1'b0); exp_w(16'h2233, 2'd1);
    fork
      do_req(0, 1'b1, 2'd0, 16'h0011);
      do_req(1, 1'b1, 2'd1, 16'h2233);
      begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
      end
    join
    wait_idle();
    exp_a(0, 1'b1); exp_r(0, 16'h0011);
    do_req(0, 1'b0, 2'd0, 16'h0000);
    wait_idle();
    exp_a(1, 1'b1); exp_r(1, 16'h2233);
    do_req(1, 1'b0, 2'd1, 16'h0000);
    wait_idle();

    // Continuous contention: six back-to-back reads alternate 0,1,0,1,0,1
    for (int i = 0; i < 3; i++) begin
      exp_a(0, 1'b1); exp_a(1, 1'b1);
    end
    exp_r(0, 16'h0011); exp_r(1, 16'hA5C3);
    exp_r(0, 16'h2233); exp_r(1, 16'h2233);
    exp_r(0, 16'hA5C3); exp_r(1, 16'h0011);
    fork
      begin
        do_req(0, 1'b0, 2'd0, 16'h0000);
        do_req(0, 1'b0, 2'd1, 16'h0000);
        do_req(0, 1'b0, 2'd2, 16'h0000);
      end
      begin
        do_req(1, 1'b0, 2'd2, 16'h0000);
        do_req(1, 1'b0, 2'd1, 16'h0000);
        do_req(1, 1'b0, 2'd0, 16'h0000);
      end
    join
    wait_idle();

    // Coherence, tie with last grant 1: read of addr 3 goes first and sees old data
    exp_a(0, 1'b1); exp_r(0, 16'h0000);
    exp_a(1, 1'b0); exp_w(16'hFFFF, 2'd3);
    fork
      do_req(0, 1'b0, 2'd3, 16'h0000);
      do_req(1, 1'b1, 2'd3, 16'hFFFF);
    join
    wait_idle();
    exp_a(0, 1'b1); exp_r(0, 16'hFFFF);
    do_req(0, 1'b0, 2'd3, 16'h0000);
    wait_idle();

    // Coherence, writer granted first: pending read returns the new data
    exp_a(1, 1'b0); exp_w(16'h1234, 2'd3);
    exp_a(0, 1'b1); exp_r(0, 16'h1234);
    fork
      do_req(1, 1'b1, 2'd3, 16'h1234);
      begin
        @(posedge clk); #1;
        do_req(0, 1'b0, 2'd3, 16'h0000);
      end
    join
    wait_idle();

    // Reset during RD2: no rd_valid, rd_data cleared, strobes low
    exp_a(0, 1'b0);
    do_req(0, 1'b0, 2'd2, 16'h0000);
    @(posedge clk); #1;
    chk("in_rd2_oe", {31'd0, mem_oe}, 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk_quiet("midrst");
    chk("midrst_rd_data", {16'd0, rd_data}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    exp_a(0, 1'b1); exp_r(0, 16'hA5C3);
    do_req(0, 1'b0, 2'd2, 16'h0000);
    wait_idle();

    repeat (5) @(posedge clk);
    #1;
    chk("ack_queue_drained", exp_ack.size(), 0);
    chk("rd_queue_drained",  exp_rd.size(),  0);
    chk("wr_queue_drained",  exp_wr.size(),  0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
